// File: rtl/mmc_cmd_ctrl_pkg.sv
// Shared encodings, frame lengths, FSM state type and the CRC7 step function
// for the MMC command-line controller.
package mmc_cmd_ctrl_pkg;

  localparam logic [1:0] RSP_NONE  = 2'b00;
  localparam logic [1:0] RSP_SHORT = 2'b01;
  localparam logic [1:0] RSP_LONG  = 2'b10;
  localparam logic [1:0] RSP_R3    = 2'b11;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int unsigned FRAME_CMD_LEN  = 48;
  localparam int unsigned FRAME_LONG_LEN = 136;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TX         = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_RX         = 3'd3,
    ST_GAP        = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  // One serial step of x^7+x^3+1, MSB-first data.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/mmc_crc7.sv
// Serial CRC7 accumulator with synchronous clear and per-bit enable.
module mmc_crc7
  import mmc_cmd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  // Clear has priority over accumulating a new bit.
  always_comb begin
    if (clr) begin
      crc_d = 7'h00;
    end else if (en) begin
      crc_d = crc7_step(crc_q, din);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mmc_cmd_ctrl.sv
// MMC CMD-line controller: card clock divider, 48-bit command serialiser,
// response capture with CRC7 and timeout checking, and the NCC idle gap.
module mmc_cmd_ctrl
  import mmc_cmd_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned RSP_TIMEOUT = 64,
  parameter int unsigned NCC         = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   rsp_type,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_crc_err,
  output logic         rsp_timeout,
  output logic         mmc_clk,
  output logic         mmc_cmd_tx,
  output logic         mmc_cmd_oe,
  input  logic         mmc_cmd_rx
);

  state_e        state_q, state_d;
  logic [15:0]   div_cnt_q, div_cnt_d;
  logic          mmc_clk_q, mmc_clk_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic [15:0]   gap_cnt_q, gap_cnt_d;
  logic [39:0]   tx_sh_q, tx_sh_d;
  logic [127:0]  rx_sh_q, rx_sh_d;
  logic [1:0]    rsp_type_q, rsp_type_d;
  logic          timeout_seen_q, timeout_seen_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [127:0]  rsp_data_q, rsp_data_d;
  logic          rsp_crc_err_q, rsp_crc_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          mmc_cmd_tx_q, mmc_cmd_tx_d;
  logic          mmc_cmd_oe_q, mmc_cmd_oe_d;

  logic          tick_s, fall_s, rise_s;
  logic          tx_crc_clr_s, tx_crc_en_s, tx_crc_bit_s;
  logic          rx_crc_clr_s, rx_crc_en_s;
  logic [6:0]    tx_crc_s, rx_crc_s;
  logic          rx_long_s, rx_last_s, rx_crc_win_s;
  logic [7:0]    rx_len_m1_s;

  assign tick_s      = (div_cnt_q == 16'(CLK_DIV - 1));
  assign fall_s      = tick_s & mmc_clk_q;
  assign rise_s      = tick_s & ~mmc_clk_q;
  assign rx_long_s   = (rsp_type_q == RSP_LONG);
  assign rx_len_m1_s = rx_long_s ? 8'(FRAME_LONG_LEN - 1) : 8'(FRAME_CMD_LEN - 1);
  assign rx_last_s   = (bit_cnt_q == rx_len_m1_s);
  // Short CRC covers received bits 47..8; long CRC skips the 8-bit header.
  assign rx_crc_win_s = rx_long_s ? ((bit_cnt_q >= 8'd8) && (bit_cnt_q <= 8'd127))
                                  : (bit_cnt_q <= 8'd39);

  mmc_crc7 u_tx_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tx_crc_clr_s),
    .en    (tx_crc_en_s),
    .din   (tx_crc_bit_s),
    .crc   (tx_crc_s)
  );

  mmc_crc7 u_rx_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rx_crc_clr_s),
    .en    (rx_crc_en_s),
    .din   (mmc_cmd_rx),
    .crc   (rx_crc_s)
  );

  // Free-running card clock divider.
  always_comb begin
    if (tick_s) begin
      div_cnt_d = 16'd0;
      mmc_clk_d = ~mmc_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + 16'd1;
      mmc_clk_d = mmc_clk_q;
    end
  end

  // Transaction FSM next-state and output computation.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    tx_sh_d        = tx_sh_q;
    rx_sh_d        = rx_sh_q;
    rsp_type_d     = rsp_type_q;
    timeout_seen_d = timeout_seen_q;
    cmd_ready_d    = cmd_ready_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    rsp_crc_err_d  = rsp_crc_err_q;
    rsp_timeout_d  = rsp_timeout_q;
    mmc_cmd_tx_d   = mmc_cmd_tx_q;
    mmc_cmd_oe_d   = mmc_cmd_oe_q;
    tx_crc_clr_s   = 1'b0;
    tx_crc_en_s    = 1'b0;
    tx_crc_bit_s   = 1'b0;
    rx_crc_clr_s   = 1'b0;
    rx_crc_en_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          tx_sh_d        = {2'b01, cmd_index, cmd_arg};
          rsp_type_d     = rsp_type;
          rx_sh_d        = 128'd0;
          bit_cnt_d      = 8'd0;
          timeout_seen_d = 1'b0;
          tx_crc_clr_s   = 1'b1;
          rx_crc_clr_s   = 1'b1;
          cmd_ready_d    = 1'b0;
          state_d        = ST_TX;
        end else begin
          cmd_ready_d    = 1'b1;
        end
      end

      ST_TX: begin
        if (fall_s) begin
          if (bit_cnt_q < 8'd40) begin
            mmc_cmd_tx_d = tx_sh_q[39];
            mmc_cmd_oe_d = 1'b1;
            tx_sh_d      = {tx_sh_q[38:0], 1'b0};
            tx_crc_en_s  = 1'b1;
            tx_crc_bit_s = tx_sh_q[39];
            bit_cnt_d    = bit_cnt_q + 8'd1;
          end else if (bit_cnt_q < 8'd47) begin
            // bit_cnt 40..46 maps onto CRC bits 6..0
            mmc_cmd_tx_d = tx_crc_s[3'd6 - bit_cnt_q[2:0]];
            mmc_cmd_oe_d = 1'b1;
            bit_cnt_d    = bit_cnt_q + 8'd1;
          end else if (bit_cnt_q == 8'd47) begin
            mmc_cmd_tx_d = 1'b1;
            mmc_cmd_oe_d = 1'b1;
            bit_cnt_d    = bit_cnt_q + 8'd1;
          end else begin
            mmc_cmd_tx_d = 1'b1;
            mmc_cmd_oe_d = 1'b0;
            bit_cnt_d    = 8'd0;
            wait_cnt_d   = 16'd0;
            gap_cnt_d    = 16'd0;
            state_d      = (rsp_type_q == RSP_NONE) ? ST_GAP : ST_WAIT_START;
          end
        end else begin
          state_d = ST_TX;
        end
      end

      ST_WAIT_START: begin
        if (rise_s) begin
          if (!mmc_cmd_rx) begin
            rx_sh_d     = {rx_sh_q[126:0], 1'b0};
            rx_crc_en_s = rx_crc_win_s;
            bit_cnt_d   = 8'd1;
            state_d     = ST_RX;
          end else if (wait_cnt_q == 16'(RSP_TIMEOUT - 1)) begin
            timeout_seen_d = 1'b1;
            gap_cnt_d      = 16'd0;
            state_d        = ST_GAP;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
        end else begin
          state_d = ST_WAIT_START;
        end
      end

      ST_RX: begin
        if (rise_s) begin
          rx_sh_d     = {rx_sh_q[126:0], mmc_cmd_rx};
          rx_crc_en_s = rx_crc_win_s;
          bit_cnt_d   = bit_cnt_q + 8'd1;
          if (rx_last_s) begin
            gap_cnt_d = 16'd0;
            state_d   = ST_GAP;
          end else begin
            state_d   = ST_RX;
          end
        end else begin
          state_d = ST_RX;
        end
      end

      ST_GAP: begin
        if (rise_s) begin
          if (gap_cnt_q == 16'(NCC - 1)) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = timeout_seen_q;
            state_d       = ST_DONE;
            if (timeout_seen_q || (rsp_type_q == RSP_NONE)) begin
              rsp_data_d    = 128'd0;
              rsp_crc_err_d = 1'b0;
            end else if (rx_long_s) begin
              rsp_data_d    = rx_sh_q;
              rsp_crc_err_d = (rx_crc_s != rx_sh_q[7:1]);
            end else begin
              rsp_data_d    = {90'd0, rx_sh_q[45:8]};
              rsp_crc_err_d = (rsp_type_q == RSP_SHORT) && (rx_crc_s != rx_sh_q[7:1]);
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 16'd1;
          end
        end else begin
          state_d = ST_GAP;
        end
      end

      ST_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        mmc_cmd_oe_d = 1'b0;
        mmc_cmd_tx_d = 1'b1;
        cmd_ready_d  = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      div_cnt_q      <= 16'd0;
      mmc_clk_q      <= 1'b0;
      bit_cnt_q      <= 8'd0;
      wait_cnt_q     <= 16'd0;
      gap_cnt_q      <= 16'd0;
      tx_sh_q        <= 40'd0;
      rx_sh_q        <= 128'd0;
      rsp_type_q     <= RSP_NONE;
      timeout_seen_q <= 1'b0;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 128'd0;
      rsp_crc_err_q  <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      mmc_cmd_tx_q   <= 1'b1;
      mmc_cmd_oe_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      mmc_clk_q      <= mmc_clk_d;
      bit_cnt_q      <= bit_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      tx_sh_q        <= tx_sh_d;
      rx_sh_q        <= rx_sh_d;
      rsp_type_q     <= rsp_type_d;
      timeout_seen_q <= timeout_seen_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_crc_err_q  <= rsp_crc_err_d;
      rsp_timeout_q  <= rsp_timeout_d;
      mmc_cmd_tx_q   <= mmc_cmd_tx_d;
      mmc_cmd_oe_q   <= mmc_cmd_oe_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_crc_err = rsp_crc_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign mmc_clk     = mmc_clk_q;
  assign mmc_cmd_tx  = mmc_cmd_tx_q;
  assign mmc_cmd_oe  = mmc_cmd_oe_q;

endmodule

// File: tb/tb_mmc_cmd_ctrl.sv
// Self-checking bench for mmc_cmd_ctrl: card model on the CMD line and a
// polynomial-division reference for frames, responses and flags.
module tb_mmc_cmd_ctrl;

  localparam int CLK_DIV     = 2;
  localparam int RSP_TIMEOUT = 64;
  localparam int NCC         = 8;
  localparam int PER         = 2 * CLK_DIV;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [5:0]   cmd_index = 6'd0;
  logic [31:0]  cmd_arg = 32'd0;
  logic [1:0]   rsp_type = 2'b00;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         rsp_crc_err;
  logic         rsp_timeout;
  logic         mmc_clk;
  logic         mmc_cmd_tx;
  logic         mmc_cmd_oe;
  logic         mmc_cmd_rx;

  logic         card_line = 1'b1;
  logic         card_drv = 1'b0;
  assign mmc_cmd_rx = card_line;

  int n_checks = 0;
  int n_fail = 0;
  logic [47:0]  tx_frame = 48'd0;
  int           oe_rises = 0;
  int           rsp_pulses = 0;
  int           contention = 0;

  bit           got_rsp;
  int           lat_clks;
  logic [127:0] cap_data;
  logic         cap_crc, cap_tmo;

  mmc_cmd_ctrl #(.CLK_DIV(CLK_DIV), .RSP_TIMEOUT(RSP_TIMEOUT), .NCC(NCC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .rsp_type(rsp_type),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_crc_err(rsp_crc_err),
    .rsp_timeout(rsp_timeout), .mmc_clk(mmc_clk), .mmc_cmd_tx(mmc_cmd_tx),
    .mmc_cmd_oe(mmc_cmd_oe), .mmc_cmd_rx(mmc_cmd_rx)
  );

  always #5 clk = ~clk;

  // Card-side view of the command frame: sampled on mmc_clk rising edges.
  always @(posedge mmc_clk) begin
    if (mmc_cmd_oe) begin
      tx_frame <= {tx_frame[46:0], mmc_cmd_tx};
      oe_rises <= oe_rises + 1;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
    if (mmc_cmd_oe && card_drv) contention <= contention + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [127:0] msg);
    logic [134:0] r;
    r = {msg, 7'b0};
    for (int i = 134; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [135:0] mk_short(input logic [37:0] p, input logic [6:0] flip);
    logic [39:0] h;
    h = {2'b00, p};
    return {88'd0, h, ref_crc7({88'd0, h}) ^ flip, 1'b1};
  endfunction

  function automatic logic [135:0] mk_long(input logic [119:0] b, input logic [6:0] flip);
    return {8'h3F, b, ref_crc7({8'd0, b}) ^ flip, 1'b1};
  endfunction

  task automatic card_respond(input string name, input int delay, input int nbits,
                              input logic [135:0] cbits);
    bit seen_hi, released;
    seen_hi = 0;
    released = 0;
    for (int i = 0; i < 2000 && !released; i++) begin
      @(negedge clk);
      if (mmc_cmd_oe) seen_hi = 1;
      else if (seen_hi) released = 1;
    end
    check_eq({name, "_oe_release"}, 136'(released), 136'd1);
    if (released && delay > 0 && nbits > 0) begin
      repeat (delay - 1) @(negedge mmc_clk);
      for (int b = nbits - 1; b >= 0; b--) begin
        card_drv = 1'b1;
        card_line = cbits[b];
        @(negedge mmc_clk);
      end
      card_drv = 1'b0;
      card_line = 1'b1;
    end
  endtask

  task automatic wait_rsp();
    got_rsp = 0;
    lat_clks = 0;
    for (int i = 0; i < 4000 && !got_rsp; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got_rsp  = 1;
        lat_clks = i + 1;
        cap_data = rsp_data;
        cap_crc  = rsp_crc_err;
        cap_tmo  = rsp_timeout;
      end
    end
  endtask

  task automatic do_txn(input string name, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [1:0] typ, input int delay, input int nbits,
                        input logic [135:0] cbits);
    logic [39:0]  hdr;
    logic [47:0]  exp_frame;
    logic [127:0] exp_data;
    bit           exp_crc, exp_tmo;
    int           base_oe, base_pulse;
    hdr       = {2'b01, idx, arg};
    exp_frame = {hdr, ref_crc7({88'd0, hdr}), 1'b1};
    exp_data  = '0;
    exp_crc   = 0;
    exp_tmo   = 0;
    if (typ != 2'b00) begin
      if (delay < 1 || delay > RSP_TIMEOUT || nbits == 0) begin
        exp_tmo = 1;
      end else if (typ == 2'b10) begin
        exp_data = cbits[127:0];
        exp_crc  = (ref_crc7({8'd0, cbits[127:8]}) != cbits[7:1]);
      end else begin
        exp_data = {90'd0, cbits[45:8]};
        exp_crc  = (typ == 2'b01) && (ref_crc7({88'd0, cbits[47:8]}) != cbits[7:1]);
      end
    end
    base_oe    = oe_rises;
    base_pulse = rsp_pulses;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    rsp_type  = typ;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_index = 6'($urandom);
    cmd_arg   = $urandom;
    rsp_type  = 2'($urandom);
    check_eq({name, "_ready_drop"}, 136'(cmd_ready), 136'd0);
    fork
      card_respond(name, delay, nbits, cbits);
      wait_rsp();
    join
    check_eq({name, "_rsp_seen"}, 136'(got_rsp), 136'd1);
    if (got_rsp) begin
      check_eq({name, "_data"}, 136'(cap_data), 136'(exp_data));
      check_eq({name, "_crc_err"}, 136'(cap_crc), 136'(exp_crc));
      check_eq({name, "_timeout"}, 136'(cap_tmo), 136'(exp_tmo));
      @(negedge clk);
      check_eq({name, "_ready_back"}, 136'(cmd_ready), 136'd1);
      if (typ == 2'b00)
        check_eq({name, "_latency_ok"},
                 136'((lat_clks >= PER * (48 + NCC - 1)) && (lat_clks <= PER * (48 + NCC + 1))),
                 136'd1);
    end
    repeat (2) @(negedge clk);
    check_eq({name, "_frame"}, 136'(tx_frame), 136'(exp_frame));
    check_eq({name, "_oe_periods"}, 136'(oe_rises - base_oe), 136'd48);
    check_eq({name, "_one_pulse"}, 136'(rsp_pulses - base_pulse), 136'd1);
  endtask

  initial begin
    logic [1:0]   typ;
    logic [6:0]   flip;
    logic [135:0] cb;
    int           dly, beh, base_oe, base_pulse;

    repeat (3) @(negedge clk);
    check_eq("rst_mmc_clk", 136'(mmc_clk), 136'd0);
    check_eq("rst_tx", 136'(mmc_cmd_tx), 136'd1);
    check_eq("rst_oe", 136'(mmc_cmd_oe), 136'd0);
    check_eq("rst_ready", 136'(cmd_ready), 136'd1);
    check_eq("rst_valid", 136'(rsp_valid), 136'd0);
    check_eq("rst_data", 136'(rsp_data), 136'd0);
    check_eq("rst_flags", 136'({rsp_crc_err, rsp_timeout}), 136'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_txn("cmd0", 6'd0, 32'd0, 2'b00, 0, 0, '0);
    check_eq("cmd0_literal", 136'(tx_frame), 136'(48'h400000000095));

    cb = 136'(48'h3F80FF8000FF);
    do_txn("cmd1_r3", 6'd1, 32'h00FF8000, 2'b11, 3, 48, cb);
    check_eq("cmd1_r3_literal", 136'(cap_data[37:0]), 136'({6'h3F, 32'h80FF8000}));

    do_txn("r1_badcrc", 6'd13, 32'h0000_0900, 2'b01, 2, 48,
           mk_short({6'd13, 32'h0000_0900}, 7'h04));
    do_txn("r1_silent", 6'd17, 32'h1234_5678, 2'b01, 0, 0, '0);
    do_txn("r2_cid", 6'd2, 32'd0, 2'b10, 5, 136,
           {8'h3F, 128'h0123456789ABCDEF_FEDCBA9876543210});
    do_txn("r2_good", 6'd9, 32'hABCD_0000, 2'b10, 1, 136,
           mk_long({$urandom, $urandom, $urandom, $urandom}, 7'h00));
    do_txn("r1_edge64", 6'd7, 32'h0001_0000, 2'b01, RSP_TIMEOUT, 48,
           mk_short({6'd7, 32'h0000_0700}, 7'h00));
    do_txn("r1_late65", 6'd7, 32'h0001_0000, 2'b01, RSP_TIMEOUT + 1, 1, '0);

    for (int n = 0; n < 8; n++) begin
      typ  = 2'($urandom_range(0, 3));
      beh  = $urandom_range(0, 3);
      dly  = $urandom_range(1, RSP_TIMEOUT);
      flip = (beh == 1) ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
      if (typ == 2'b10) cb = mk_long({$urandom, $urandom, $urandom, $urandom}, flip);
      else cb = mk_short({6'($urandom), $urandom}, flip);
      if (typ == 2'b00 || beh == 2) dly = 0;
      do_txn($sformatf("rnd%0d", n), 6'($urandom), $urandom, typ, dly,
             (typ == 2'b10) ? 136 : 48, cb);
    end

    base_oe    = oe_rises;
    base_pulse = rsp_pulses;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_index = 6'd17;
    cmd_arg   = $urandom;
    rsp_type  = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 400 && (oe_rises - base_oe) < 20; i++) @(negedge clk);
    check_eq("rst_mid_bit20", 136'(oe_rises - base_oe), 136'd20);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_oe", 136'(mmc_cmd_oe), 136'd0);
    check_eq("rst_mid_ready", 136'(cmd_ready), 136'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check_eq("rst_mid_no_valid", 136'(rsp_pulses - base_pulse), 136'd0);
    check_eq("rst_mid_ready_after", 136'(cmd_ready), 136'd1);
    check_eq("rst_mid_oe_after", 136'(mmc_cmd_oe), 136'd0);

    do_txn("cmd0_after_rst", 6'd0, 32'd0, 2'b00, 0, 0, '0);
    check_eq("cmd0_after_rst_literal", 136'(tx_frame), 136'(48'h400000000095));
    check_eq("no_contention", 136'(contention), 136'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
